// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: operation codes, default latencies, controller states
// and a small decode helper.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage to MDU issue bus plus the HI/LO and busy results.
// Handshake: start is valid, ~busy is ready, and flush cancels a start in its
// own cycle; an op is accepted only on an edge where start & ~flush & ~busy.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdu_op, rs_val, rt_val, flush,
                  input  busy, hi, lo);
  modport slave  (input  start, mdu_op, rs_val, rt_val, flush,
                  output busy, hi, lo);
endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational multiply/divide datapath; produces the HI/LO pair for an op.
import mdu_ctrl_pkg::*;

module mdu_ctrl_arith (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q_raw;
  logic [31:0] r_raw;
  logic        signed_div;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
  assign signed_div = (op == MDU_DIV);
  assign mag_a      = a[31] ? (~a + 32'd1) : a;
  assign mag_b      = b[31] ? (~b + 32'd1) : b;
  assign dvd        = signed_div ? mag_a : a;
  assign dvs        = signed_div ? mag_b : b;
  assign div_zero   = (b == 32'd0);
  assign q_raw      = dvd / (div_zero ? 32'd1 : dvs);
  assign r_raw      = dvd % (div_zero ? 32'd1 : dvs);

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MDU_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDU_DIV: begin
        res_lo = (a[31] ^ b[31]) ? (~q_raw + 32'd1) : q_raw;
        res_hi = a[31] ? (~r_raw + 32'd1) : r_raw;
      end
      MDU_DIVU: begin
        res_lo = q_raw;
        res_hi = r_raw;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: owns HI/LO, sequences fixed-latency multiply/divide and
// raises busy so the hazard unit stalls dependent instructions.
import mdu_ctrl_pkg::*;

module mdu_ctrl #(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  mdu_ctrl_if.slave        bus,
  output mdu_state_t       state_dbg
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_t  state;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;
  logic        accept;

  mdu_ctrl_arith u_arith (
    .op       (bus.mdu_op),
    .a        (bus.rs_val),
    .b        (bus.rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign accept    = bus.start & ~bus.flush & ~busy_q;
  assign bus.busy  = busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul_op(bus.mdu_op) || is_div_op(bus.mdu_op)) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              // A divide by zero still takes full latency but commits nothing.
              pend_wr <= ~(is_div_op(bus.mdu_op) & div_zero);
              cnt     <= is_mul_op(bus.mdu_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              busy_q  <= 1'b1;
              state   <= ST_RUN;
            end else if (bus.mdu_op == MDU_MTHI) begin
              hi_q <= bus.rs_val;
            end else if (bus.mdu_op == MDU_MTLO) begin
              lo_q <= bus.rs_val;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (pend_wr) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
            pend_wr <= 1'b0;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed cases plus random ops against a plain
// arithmetic model of HI/LO and busy timing.
import mdu_ctrl_pkg::*;

module tb_mdu_ctrl;

  localparam int T_MULT = 5;
  localparam int T_DIV  = 10;

  logic       clk;
  logic       reset;
  mdu_state_t state_dbg;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(T_MULT), .DIV_CYCLES(T_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_chk;
  int          n_pass;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Reference: {hi, lo} from 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); return p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      3'd2: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called and returns at 1 time unit after a rising edge, with the DUT idle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic fl, input logic intrude);
    int          lat;
    logic [63:0] r;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    lat    = 0;
    if (!fl) begin
      if (op <= 3'd3) begin
        lat = (op <= 3'd1) ? T_MULT : T_DIV;
        if ((op >= 3'd2) && (b == 32'd0)) begin
          exp_q.push_back(m_hi);
          exp_q.push_back(m_lo);
        end else begin
          r = ref_result(op, a, b);
          exp_q.push_back(r[63:32]);
          exp_q.push_back(r[31:0]);
        end
      end else if (op == 3'd4) begin
        m_hi = a;
      end else if (op == 3'd5) begin
        m_lo = a;
      end
    end
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.flush  = fl;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      check({tag, " hi held"}, bus.hi, old_hi);
      check({tag, " lo held"}, bus.lo, old_lo);
      if (intrude && i == 0) begin
        bus.start  = 1'b1;
        bus.mdu_op = MDU_MTHI;
        bus.rs_val = 32'h0000_1234;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    if (lat > 0) begin
      m_hi = exp_q.pop_front();
      m_lo = exp_q.pop_front();
    end
    check({tag, " busy low"}, 32'(bus.busy), 32'd0);
    check({tag, " hi"}, bus.hi, m_hi);
    check({tag, " lo"}, bus.lo, m_lo);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] ra;
  logic [31:0] rb;
  logic [2:0]  rop;
  logic        rfl;

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    m_hi       = '0;
    m_lo       = '0;
    bus.start  = 1'b0;
    bus.mdu_op = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.flush  = 1'b0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("mult_signed", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check("mult_signed hi const", bus.hi, 32'hFFFF_FFFF);
    check("mult_signed lo const", bus.lo, 32'hFFFF_FFFA);
    run_op("div_signed", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_signed lo const", bus.lo, 32'hFFFF_FFFD);
    check("div_signed hi const", bus.hi, 32'hFFFF_FFFF);
    run_op("divu", MDU_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu lo const", bus.lo, 32'd3);
    check("divu hi const", bus.hi, 32'd1);
    run_op("div0", MDU_DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
    check("div0 hi const", bus.hi, 32'd1);
    check("div0 lo const", bus.lo, 32'd3);
    run_op("flush_mult", MDU_MULT, 32'd9, 32'd9, 1'b1, 1'b0);
    run_op("mthi_busy", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    check("mthi_busy hi const", bus.hi, 32'd1);
    run_op("mtlo", MDU_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    check("mtlo lo const", bus.lo, 32'hDEAD_BEEF);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf lo const", bus.lo, 32'h8000_0000);
    check("div_ovf hi const", bus.hi, 32'd0);
    run_op("mthi", MDU_MTHI, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0);
    run_op("undef6", 3'd6, 32'h1111_1111, 32'd3, 1'b0, 1'b0);
    run_op("undef7", 3'd7, 32'h2222_2222, 32'd0, 1'b0, 1'b0);
    run_op("div_negdiv", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom();
      rb  = $urandom();
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 17));
        default: ;
      endcase
      rfl = ($urandom_range(0, 3) == 0);
      run_op("rand", rop, ra, rb, rfl, 1'b0);
    end

    // Reset while a multiply is running: async clear, no late commit.
    run_op("pre_rst", MDU_MTLO, 32'h0BAD_F00D, 32'd0, 1'b0, 1'b0);
    bus.start  = 1'b1;
    bus.mdu_op = MDU_MULT;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("rst_mid busy before", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid busy", 32'(bus.busy), 32'd0);
    check("rst_mid hi", bus.hi, 32'd0);
    check("rst_mid lo", bus.lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < T_MULT + 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_mid no commit busy", 32'(bus.busy), 32'd0);
      check("rst_mid no commit lo", bus.lo, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
